branch_tracker: RTL and testbench

BRANCH_TRACKER -- requirements
Module: branch_tracker

---
 rtl/branch_pkg.sv | 38 +++
 rtl/branch_cond_eval.sv | 43 ++++
 rtl/branch_tracker.sv | 135 +++++++++++++
 tb/tb_branch_tracker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared types for the branch tracker: branch condition codes,
//               the per-stage control entry and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Branch condition codes carried down the pipe
    typedef enum logic [2:0] {
        COND_NONE = 3'd0,
        COND_B    = 3'd1,
        COND_BE   = 3'd2,
        COND_BLT  = 3'd3,
        COND_BLE  = 3'd4,
        COND_BNE  = 3'd5,
        COND_BGE  = 3'd6,
        COND_BGT  = 3'd7
    } cond_e;

    // Control part of one tracker stage; addresses are held alongside
    // because their width is a per-instance parameter.
    typedef struct packed {
        cond_e cond;
        logic  pred;
    } entry_t;

    localparam entry_t     c_EMPTY_ENTRY = '{cond: COND_NONE, pred: 1'b0};
    localparam logic [31:0] c_STAT_MAX   = 32'hFFFF_FFFF;

    // An entry is live when it carries a real branch
    function automatic logic cond_is_branch(input cond_e cond);
        return (cond != COND_NONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond_eval
// Description : Purely combinational branch outcome from condition code and
//               the writeback flags S/Z/C/V.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond_eval
    import branch_pkg::*;
(
    input  cond_e cond,
    input  logic  S,
    input  logic  Z,
    input  logic  C,
    input  logic  V,
    output logic  taken
);

    // Carry is part of the flag bundle but no current code tests it
    logic w_unused_c;
    assign w_unused_c = C;

    logic w_lt;
    assign w_lt = S ^ V;

    // Decode the condition against the flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NONE: taken = 1'b0;
            COND_B:    taken = 1'b1;
            COND_BE:   taken = Z;
            COND_BLT:  taken = w_lt;
            COND_BLE:  taken = Z | w_lt;
            COND_BNE:  taken = ~Z;
            COND_BGE:  taken = ~w_lt;
            COND_BGT:  taken = ~Z & ~w_lt;
            default:   taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : branch_tracker
// Description : Carries issued branches through DEPTH stages to resolution,
//               evaluates the outcome at the head and reports mispredicts
//               and the corrected next address.
//               Optional statistics counters: define BRANCH_TRACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int PCW        = 16,
    parameter int SELF_FLUSH = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           stall,
    input  logic           bubble,
    input  logic [2:0]     in_cond,
    input  logic           in_pred,
    input  logic [PCW-1:0] in_target,
    input  logic [PCW-1:0] in_fallthru,
    input  logic           S,
    input  logic           Z,
    input  logic           C,
    input  logic           V,
    output logic           res_valid,
    output logic [2:0]     res_cond,
    output logic           taken,
    output logic           mispredict,
    output logic [PCW-1:0] redirect_pc,
    output logic           busy,
    output logic [31:0]    stat_branches,
    output logic [31:0]    stat_mispredicts
);

    localparam int c_HEAD = DEPTH - 1;

    entry_t         r_ent [DEPTH];
    logic [PCW-1:0] r_tgt [DEPTH];
    logic [PCW-1:0] r_ft  [DEPTH];

    cond_e w_head_cond;
    logic  w_taken_raw;
    logic  w_any_valid;
    logic  w_self_clear;

    assign w_head_cond = r_ent[c_HEAD].cond;

    branch_cond_eval u_cond_eval (
        .cond  (w_head_cond),
        .S     (S),
        .Z     (Z),
        .C     (C),
        .V     (V),
        .taken (w_taken_raw)
    );

    // Outputs are forced quiet while reset is asserted, since the entries
    // only clear on the reset edge itself.
    assign res_valid   = ~reset & cond_is_branch(w_head_cond);
    assign res_cond    = w_head_cond;
    assign taken       = ~reset & w_taken_raw;
    assign mispredict  = res_valid & (taken != r_ent[c_HEAD].pred) & ~stall & ~flush;
    assign redirect_pc = taken ? r_tgt[c_HEAD] : r_ft[c_HEAD];
    assign busy        = ~reset & w_any_valid;

    // A resolved mispredict discards everything younger than the head
    assign w_self_clear = (SELF_FLUSH != 0) & mispredict;

    // OR of all stage valids
    always_comb begin
        w_any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_any_valid = w_any_valid | cond_is_branch(r_ent[i].cond);
        end
    end

    // Stage shift register: reset > flush > stall > self-clear > shift
    always_ff @(posedge clk) begin
        if (reset || flush || (!stall && w_self_clear)) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= c_EMPTY_ENTRY;
                r_tgt[i] <= '0;
                r_ft[i]  <= '0;
            end
        end else if (!stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_ent[i] <= r_ent[i-1];
                r_tgt[i] <= r_tgt[i-1];
                r_ft[i]  <= r_ft[i-1];
            end
            if (bubble) begin
                r_ent[0] <= c_EMPTY_ENTRY;
                r_tgt[0] <= '0;
                r_ft[0]  <= '0;
            end else begin
                r_ent[0] <= '{cond: cond_e'(in_cond), pred: in_pred};
                r_tgt[0] <= in_target;
                r_ft[0]  <= in_fallthru;
            end
        end
    end

`ifdef BRANCH_TRACKER_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Saturating resolution / mispredict counters, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (res_valid && !stall && !flush && (r_stat_branches != c_STAT_MAX)) begin
                r_stat_branches <= r_stat_branches + 32'd1;
            end
            if (mispredict && (r_stat_mispredicts != c_STAT_MAX)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_tracker
// Description : Self-checking bench for branch_tracker: directed scenarios
//               followed by random traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_tracker;

    localparam int DEPTH      = 2;
    localparam int PCW        = 16;
    localparam int SELF_FLUSH = 1;

    logic           clk = 1'b0;
    logic           reset, flush, stall, bubble;
    logic [2:0]     in_cond;
    logic           in_pred;
    logic [PCW-1:0] in_target, in_fallthru;
    logic           S, Z, C, V;
    logic           res_valid;
    logic [2:0]     res_cond;
    logic           taken, mispredict, busy;
    logic [PCW-1:0] redirect_pc;
    logic [31:0]    stat_branches, stat_mispredicts;

    always #5 clk = ~clk;

    branch_tracker #(.DEPTH(DEPTH), .PCW(PCW), .SELF_FLUSH(SELF_FLUSH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .stall(stall), .bubble(bubble),
        .in_cond(in_cond), .in_pred(in_pred), .in_target(in_target),
        .in_fallthru(in_fallthru), .S(S), .Z(Z), .C(C), .V(V),
        .res_valid(res_valid), .res_cond(res_cond), .taken(taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .busy(busy),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    // Model: a queue of in-flight branches, index 0 youngest, last = head
    typedef struct {
        int          cond;
        bit          pred;
        int unsigned tgt;
        int unsigned ft;
    } ment_t;

    ment_t       mq[$];
    longint      exp_br, exp_mp;
    int          n_cmp, n_bad;
    bit          first_cycle;

    function automatic bit eval_taken(int cond, bit s, bit z, bit v);
        case (cond)
            1:       return 1'b1;
            2:       return z;
            3:       return s ^ v;
            4:       return z | (s ^ v);
            5:       return !z;
            6:       return !(s ^ v);
            7:       return !z && !(s ^ v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic ment_t empty_ent();
        ment_t e;
        e.cond = 0; e.pred = 0; e.tgt = 0; e.ft = 0;
        return e;
    endfunction

    task automatic clear_model();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back(empty_ent());
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, check outputs, advance the model (no edge yet)
    task automatic step_nowait(input bit rst, input bit fl, input bit st, input bit bu,
                               input int cnd, input bit p, input int unsigned t,
                               input int unsigned f, input bit s, input bit z,
                               input bit cc, input bit v);
        ment_t head, ne;
        bit    mv, mt, mm, mb;
        reset = rst; flush = fl; stall = st; bubble = bu;
        in_cond = 3'(cnd); in_pred = p; in_target = PCW'(t); in_fallthru = PCW'(f);
        S = s; Z = z; C = cc; V = v;
        #1;
        head = mq[DEPTH-1];
        mv = !rst && head.cond != 0;
        mt = !rst && eval_taken(head.cond, s, z, v);
        mm = mv && (mt != head.pred) && !st && !fl;
        mb = 1'b0;
        foreach (mq[i]) if (mq[i].cond != 0) mb = 1'b1;
        mb = mb && !rst;
        chk("res_valid", res_valid, mv);
        chk("taken", taken, mt);
        chk("mispredict", mispredict, mm);
        chk("busy", busy, mb);
        if (mv) begin
            chk("res_cond", res_cond, head.cond);
            chk("redirect_pc", redirect_pc, mt ? head.tgt : head.ft);
        end
        if (!first_cycle) begin
`ifdef BRANCH_TRACKER_STATS_EN
            chk("stat_branches", stat_branches, exp_br);
            chk("stat_mispredicts", stat_mispredicts, exp_mp);
`else
            chk("stat_branches", stat_branches, 0);
            chk("stat_mispredicts", stat_mispredicts, 0);
`endif
        end
        first_cycle = 1'b0;
        if (rst) begin
            clear_model();
            exp_br = 0; exp_mp = 0;
        end else if (fl) begin
            clear_model();
        end else if (!st) begin
            if (mv && exp_br < 64'hFFFF_FFFF) exp_br++;
            if (mm && exp_mp < 64'hFFFF_FFFF) exp_mp++;
            if (mm && SELF_FLUSH != 0) begin
                clear_model();
            end else begin
                void'(mq.pop_back());
                ne = empty_ent();
                if (!bu) begin
                    ne.cond = cnd; ne.pred = p;
                    ne.tgt = t & 32'hFFFF; ne.ft = f & 32'hFFFF;
                end
                mq.push_front(ne);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic step(input bit rst, input bit fl, input bit st, input bit bu,
                        input int cnd, input bit p, input int unsigned t,
                        input int unsigned f, input bit s, input bit z,
                        input bit cc, input bit v);
        step_nowait(rst, fl, st, bu, cnd, p, t, f, s, z, cc, v);
        tick();
    endtask

    // Idle bubble cycle with given flags
    task automatic idle(input bit s, input bit z, input bit v);
        step(0, 0, 0, 1, 0, 0, 0, 0, s, z, 0, v);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; exp_br = 0; exp_mp = 0; first_cycle = 1'b1;
        clear_model();

        // Reset, two cycles
        step(1, 0, 0, 0, 1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 1, 16'h1111, 16'h2222, 0, 0, 0, 0);
        idle(0, 0, 0);

        // BE predicted not-taken, Z rises when it reaches the head
        step(0, 0, 0, 0, 2, 0, 16'h1234, 16'h5678, 0, 0, 0, 0);
        idle(0, 0, 0);
        step_nowait(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("be_valid", res_valid, 1);
        chk("be_taken", taken, 1);
        chk("be_mispredict", mispredict, 1);
        chk("be_redirect", redirect_pc, 16'h1234);
        tick();

        // BLT predicted taken, not taken (S==V), stalled three cycles at head
        step(0, 0, 0, 0, 3, 1, 16'hA000, 16'hB000, 0, 0, 0, 0);
        idle(0, 0, 0);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1);
        step_nowait(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        chk("blt_mispredict", mispredict, 1);
        chk("blt_redirect", redirect_pc, 16'hB000);
        tick();

        // B predicted not-taken at head, BNE behind it is discarded
        step(0, 0, 0, 0, 1, 0, 16'h0100, 16'h0200, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 1, 16'h0300, 16'h0400, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_nowait(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("selfflush_busy", busy, 0);
        tick();
        idle(0, 0, 0);
        idle(0, 0, 0);

        // Flush while stalled with two valid entries
        step(0, 0, 0, 0, 6, 0, 16'h0AAA, 16'h0BBB, 0, 0, 0, 0);
        step(0, 0, 0, 0, 7, 1, 16'h0CCC, 16'h0DDD, 0, 1, 0, 0);
        step(0, 1, 1, 0, 1, 1, 16'h0EEE, 16'h0FFF, 0, 0, 0, 0);
        step_nowait(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush_busy", busy, 0);
        tick();

        // Bubble overrides a valid in_cond
        step(0, 0, 0, 1, 1, 1, 16'h7777, 16'h8888, 0, 0, 0, 0);
        idle(0, 0, 0);
        step_nowait(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bubble_valid", res_valid, 0);
        tick();

`ifdef BRANCH_TRACKER_STATS_EN
        // Preload mispredict counter just below saturation
        force dut.r_stat_mispredicts = 32'hFFFF_FFFE;
        #1;
        release dut.r_stat_mispredicts;
        exp_mp = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 0, 16'h0010, 16'h0020, 0, 0, 0, 0);
            idle(0, 0, 0);
            idle(0, 0, 0);
        end
        chk("sat_mispredicts", stat_mispredicts, 32'hFFFF_FFFF);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(99) == 0,
                 $urandom_range(19) == 0,
                 $urandom_range(4) == 0,
                 $urandom_range(5) == 0,
                 $urandom_range(7), $urandom_range(1),
                 $urandom_range(16'hFFFF), $urandom_range(16'hFFFF),
                 $urandom_range(1), $urandom_range(1),
                 $urandom_range(1), $urandom_range(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
